// File: rtl/dma_pkg.sv
// Shared types for the DMA sink: FSM states, interrupt bit positions and the buffered beat.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN,
        WAIT_ACK
    } dma_sink_state_e;

    localparam int INT_DONE = 0;
    localparam int INT_ERR  = 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

endpackage

// File: rtl/dma_fifo.sv
// Synchronous FIFO with registered storage and no write-to-read bypass.
// Pointers carry one extra MSB so full and empty can be told apart.
module dma_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/dma_sink.sv
// Responder end of the CPU DMA interface: buffers single-beat writes, drains them to a
// device port and raises sticky interrupts. Optional address check: DMA_SINK_ADDR_CHECK_EN.
module dma_sink
    import dma_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] memAddr,
    input  logic [31:0] memDataOut,
    input  logic        ack,
    output logic        nextTransaction,
    output logic [1:0]  Interrupt,
    output logic        dev_valid,
    output logic [31:0] dev_addr,
    output logic [31:0] dev_data,
    input  logic        dev_ready
);

    localparam int CW = $clog2(BURST_LEN + 1);

    dma_sink_state_e r_state;
    logic [CW-1:0]   r_acc_cnt;
    logic [CW-1:0]   r_drn_cnt;
    logic [1:0]      r_int;
    logic            r_out_en;

    beat_t           w_wbeat;
    beat_t           w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_accept;
    logic            w_pop;
    logic            w_acc_last;
    logic            w_drn_last;
    logic            w_enter_wait;
    logic            w_addr_err;
    logic            w_err;

    // Ready is decoded from flops only; r_out_en keeps it low until the first edge after reset.
    assign nextTransaction = r_out_en && !w_full &&
                             ((r_state == IDLE) || (r_state == ACTIVE));

    assign w_accept     = en && nextTransaction;
    assign w_pop        = !w_empty && dev_ready;
    assign w_acc_last   = (r_acc_cnt == CW'(BURST_LEN - 1));
    assign w_drn_last   = (r_drn_cnt == CW'(BURST_LEN - 1));
    assign w_enter_wait = (r_state == DRAIN) && w_pop && w_drn_last;
    assign w_err        = (en && !nextTransaction) || w_addr_err;

    assign w_wbeat = '{addr: memAddr, data: memDataOut};

    dma_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_accept),
        .pop   (w_pop),
        .wdata (w_wbeat),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

`ifdef DMA_SINK_ADDR_CHECK_EN
    logic [31:0] r_exp_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp_addr <= '0;
        end else if (w_accept) begin
            r_exp_addr <= memAddr + 32'd4;
        end
    end

    // Only beats after the first of a burst are checked; the first one seeds the expectation.
    assign w_addr_err = w_accept && (r_state == ACTIVE) && (memAddr != r_exp_addr);
`else
    assign w_addr_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_acc_cnt <= '0;
            r_drn_cnt <= '0;
            r_int     <= 2'b00;
            r_out_en  <= 1'b0;
        end else begin
            r_out_en <= 1'b1;
            if (w_accept) r_acc_cnt <= r_acc_cnt + 1'b1;
            if (w_pop)    r_drn_cnt <= r_drn_cnt + 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_accept) r_state <= w_acc_last ? DRAIN : ACTIVE;
                end
                ACTIVE: begin
                    if (w_accept && w_acc_last) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (w_enter_wait) r_state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // The ack that clears the done bit is the one that ends the burst.
                    if (ack && !r_int[INT_ERR]) begin
                        r_state   <= IDLE;
                        r_acc_cnt <= '0;
                        r_drn_cnt <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // An ack services the error bit first; a same-cycle error wins over its clear.
            if (w_err)     r_int[INT_ERR] <= 1'b1;
            else if (ack)  r_int[INT_ERR] <= 1'b0;

            if (w_enter_wait)                 r_int[INT_DONE] <= 1'b1;
            else if (ack && !r_int[INT_ERR])  r_int[INT_DONE] <= 1'b0;
        end
    end

    assign Interrupt = r_int;
    assign dev_valid = !w_empty;
    assign dev_addr  = w_empty ? 32'd0 : w_head.addr;
    assign dev_data  = w_empty ? 32'd0 : w_head.data;

endmodule

// File: tb/tb_dma_sink.sv
// Directed bench for dma_sink with DEPTH=2, BURST_LEN=4; expectations follow the
// DMA_SINK_ADDR_CHECK_EN define when it is set for the build.
module tb_dma_sink;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] memAddr;
    logic [31:0] memDataOut;
    logic        ack;
    logic        nextTransaction;
    logic [1:0]  Interrupt;
    logic        dev_valid;
    logic [31:0] dev_addr;
    logic [31:0] dev_data;
    logic        dev_ready;

    int vec  = 0;
    int miss = 0;

`ifdef DMA_SINK_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    dma_sink #(
        .DEPTH     (2),
        .BURST_LEN (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .memAddr         (memAddr),
        .memDataOut      (memDataOut),
        .ack             (ack),
        .nextTransaction (nextTransaction),
        .Interrupt       (Interrupt),
        .dev_valid       (dev_valid),
        .dev_addr        (dev_addr),
        .dev_data        (dev_data),
        .dev_ready       (dev_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    // Streams four back-to-back beats with the device always ready; skip adds 4 to beats 2..3.
    task automatic stream_burst(input logic [31:0] base, input logic [31:0] dbase, input bit skip,
                                input logic exp_mid_err, input logic [1:0] exp_end);
        logic [31:0] a;
        logic [31:0] d;
        dev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = base + 32'(4 * i) + ((skip && i >= 2) ? 32'd4 : 32'd0);
            d = dbase + 32'(i);
            vec++;
            if (nextTransaction !== 1'b1) begin
                miss++;
                $display("FAIL burst_ready beat %0d: got %b expected 1", i, nextTransaction);
            end
            en = 1'b1; memAddr = a; memDataOut = d;
            tick();
            vec++;
            if (dev_valid !== 1'b1 || dev_addr !== a || dev_data !== d) begin
                miss++;
                $display("FAIL burst_head beat %0d: got v=%b a=%h d=%h expected v=1 a=%h d=%h",
                         i, dev_valid, dev_addr, dev_data, a, d);
            end
            if (i == 2) begin
                vec++;
                if (Interrupt[1] !== exp_mid_err) begin
                    miss++;
                    $display("FAIL burst_mid_err: got %b expected %b", Interrupt[1], exp_mid_err);
                end
            end
        end
        en = 1'b0;
        vec++;
        if (nextTransaction !== 1'b0) begin
            miss++;
            $display("FAIL burst_drain_ready: got %b expected 0", nextTransaction);
        end
        tick();
        vec++;
        if (Interrupt !== exp_end || dev_valid !== 1'b0 || nextTransaction !== 1'b0) begin
            miss++;
            $display("FAIL burst_end: got int=%b v=%b nt=%b expected int=%b v=0 nt=0",
                     Interrupt, dev_valid, nextTransaction, exp_end);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; ack = 1'b0; dev_ready = 1'b0;
        memAddr = '0; memDataOut = '0;
        repeat (2) tick();
        vec++;
        if (nextTransaction !== 1'b0 || Interrupt !== 2'b00 || dev_valid !== 1'b0 ||
            dev_addr !== 32'd0 || dev_data !== 32'd0) begin
            miss++;
            $display("FAIL reset_outputs: got nt=%b int=%b v=%b a=%h d=%h expected all zero",
                     nextTransaction, Interrupt, dev_valid, dev_addr, dev_data);
        end
        rst_n = 1'b1;
        tick();
        vec++;
        if (nextTransaction !== 1'b1 || Interrupt !== 2'b00) begin
            miss++;
            $display("FAIL reset_release: got nt=%b int=%b expected nt=1 int=00",
                     nextTransaction, Interrupt);
        end
    endtask

    task automatic test_back_to_back();
        stream_burst(32'h100, 32'hA0, 1'b0, 1'b0, 2'b01);
        tick();
        vec++;
        if (Interrupt !== 2'b01 || nextTransaction !== 1'b0) begin
            miss++;
            $display("FAIL b2b_hold: got int=%b nt=%b expected int=01 nt=0", Interrupt, nextTransaction);
        end
        pulse_ack();
        vec++;
        if (Interrupt !== 2'b00 || nextTransaction !== 1'b1) begin
            miss++;
            $display("FAIL b2b_ack: got int=%b nt=%b expected int=00 nt=1", Interrupt, nextTransaction);
        end
    endtask

    task automatic test_full_backpressure();
        dev_ready = 1'b0;
        en = 1'b1; memAddr = 32'h100; memDataOut = 32'hA0;
        tick();
        vec++;
        if (nextTransaction !== 1'b1) begin
            miss++;
            $display("FAIL full_one_entry: got nt=%b expected 1", nextTransaction);
        end
        memAddr = 32'h104; memDataOut = 32'hA1;
        tick();
        vec++;
        if (nextTransaction !== 1'b0) begin
            miss++;
            $display("FAIL full_two_entries: got nt=%b expected 0", nextTransaction);
        end
        memAddr = 32'h108; memDataOut = 32'hA2;
        tick();
        en = 1'b0;
        vec++;
        if (Interrupt !== 2'b10 || nextTransaction !== 1'b0) begin
            miss++;
            $display("FAIL full_overrun_err: got int=%b nt=%b expected int=10 nt=0", Interrupt, nextTransaction);
        end
        vec++;
        if (dev_valid !== 1'b1 || dev_addr !== 32'h100 || dev_data !== 32'hA0) begin
            miss++;
            $display("FAIL full_head_stable: got v=%b a=%h d=%h expected v=1 a=100 d=a0",
                     dev_valid, dev_addr, dev_data);
        end
        dev_ready = 1'b1;
        tick();
        vec++;
        if (dev_valid !== 1'b1 || dev_addr !== 32'h104 || dev_data !== 32'hA1) begin
            miss++;
            $display("FAIL full_drain_second: got v=%b a=%h d=%h expected v=1 a=104 d=a1",
                     dev_valid, dev_addr, dev_data);
        end
        tick();
        vec++;
        if (dev_valid !== 1'b0 || nextTransaction !== 1'b1) begin
            miss++;
            $display("FAIL full_drained: got v=%b nt=%b expected v=0 nt=1", dev_valid, nextTransaction);
        end
        // Finish the burst with the error still pending so both interrupt bits end up set.
        en = 1'b1; memAddr = 32'h108; memDataOut = 32'hA2;
        tick();
        vec++;
        if (dev_addr !== 32'h108 || dev_data !== 32'hA2) begin
            miss++;
            $display("FAIL full_third_head: got a=%h d=%h expected a=108 d=a2", dev_addr, dev_data);
        end
        memAddr = 32'h10C; memDataOut = 32'hA3;
        tick();
        en = 1'b0;
        vec++;
        if (dev_addr !== 32'h10C || dev_data !== 32'hA3 || nextTransaction !== 1'b0) begin
            miss++;
            $display("FAIL full_fourth_head: got a=%h d=%h nt=%b expected a=10c d=a3 nt=0",
                     dev_addr, dev_data, nextTransaction);
        end
        tick();
        vec++;
        if (Interrupt !== 2'b11 || dev_valid !== 1'b0) begin
            miss++;
            $display("FAIL full_both_int: got int=%b v=%b expected int=11 v=0", Interrupt, dev_valid);
        end
    endtask

    task automatic test_ack_priority();
        pulse_ack();
        vec++;
        if (Interrupt !== 2'b01 || nextTransaction !== 1'b0) begin
            miss++;
            $display("FAIL ack_clears_err: got int=%b nt=%b expected int=01 nt=0", Interrupt, nextTransaction);
        end
        pulse_ack();
        vec++;
        if (Interrupt !== 2'b00 || nextTransaction !== 1'b1) begin
            miss++;
            $display("FAIL ack_clears_done: got int=%b nt=%b expected int=00 nt=1", Interrupt, nextTransaction);
        end
    endtask

    task automatic test_err_wait_ack();
        stream_burst(32'h300, 32'hC0, 1'b0, 1'b0, 2'b01);
        en = 1'b1; memAddr = 32'h400; memDataOut = 32'hDD;
        tick();
        en = 1'b0;
        vec++;
        if (Interrupt !== 2'b11 || nextTransaction !== 1'b0 || dev_valid !== 1'b0) begin
            miss++;
            $display("FAIL wait_en_err: got int=%b nt=%b v=%b expected int=11 nt=0 v=0",
                     Interrupt, nextTransaction, dev_valid);
        end
        en = 1'b1; ack = 1'b1;
        tick();
        en = 1'b0; ack = 1'b0;
        vec++;
        if (Interrupt !== 2'b11) begin
            miss++;
            $display("FAIL err_ack_same_cycle: got int=%b expected 11", Interrupt);
        end
        test_ack_priority();
    endtask

    task automatic test_reset_mid_burst();
        dev_ready = 1'b0;
        en = 1'b1; memAddr = 32'h500; memDataOut = 32'hD0;
        tick();
        memAddr = 32'h504; memDataOut = 32'hD1;
        tick();
        memAddr = 32'h508; memDataOut = 32'hD2;
        tick();
        en = 1'b0;
        vec++;
        if (Interrupt !== 2'b10 || dev_valid !== 1'b1) begin
            miss++;
            $display("FAIL midrst_pre: got int=%b v=%b expected int=10 v=1", Interrupt, dev_valid);
        end
        rst_n = 1'b0;
        #1;
        vec++;
        if (nextTransaction !== 1'b0 || Interrupt !== 2'b00 || dev_valid !== 1'b0 ||
            dev_addr !== 32'd0 || dev_data !== 32'd0) begin
            miss++;
            $display("FAIL midrst_outputs: got nt=%b int=%b v=%b a=%h d=%h expected all zero",
                     nextTransaction, Interrupt, dev_valid, dev_addr, dev_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        stream_burst(32'h600, 32'hE0, 1'b0, 1'b0, 2'b01);
        pulse_ack();
        vec++;
        if (Interrupt !== 2'b00 || nextTransaction !== 1'b1) begin
            miss++;
            $display("FAIL midrst_recover: got int=%b nt=%b expected int=00 nt=1", Interrupt, nextTransaction);
        end
    endtask

    task automatic test_addr_check();
        stream_burst(32'h100, 32'hB0, 1'b1, CHK, {CHK, 1'b1});
        pulse_ack();
        vec++;
        if (Interrupt !== {1'b0, CHK}) begin
            miss++;
            $display("FAIL addr_first_ack: got int=%b expected %b", Interrupt, {1'b0, CHK});
        end
        pulse_ack();
        vec++;
        if (Interrupt !== 2'b00 || nextTransaction !== 1'b1) begin
            miss++;
            $display("FAIL addr_final_ack: got int=%b nt=%b expected int=00 nt=1", Interrupt, nextTransaction);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_full_backpressure();
        test_ack_priority();
        test_err_wait_ack();
        test_reset_mid_burst();
        test_addr_check();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
